// File: rtl/jtag_pkg.sv
// Shared types, PHY command encodings and packet packing for the JTAG scan scheduler.
package jtag_pkg;

  localparam logic [2:0] CMD_WR_DR = 3'b000;
  localparam logic [2:0] CMD_RD_DR = 3'b001;
  localparam logic [2:0] CMD_WR_IR = 3'b100;

  // Packing works on a wide canvas; callers zero-extend inputs and keep the low bits.
  localparam int PK_DATA_MAX = 512;
  localparam int PK_LEN_MAX  = 32;
  localparam int PK_W_MAX    = PK_DATA_MAX + PK_LEN_MAX + 3;

  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_IR, S_DR, S_DRAIN, S_FIN} state_t;

  function automatic int len_w(input int max_clen);
    return $clog2(max_clen);
  endfunction

  function automatic int buf_w(input int buf_sz);
    return $clog2(buf_sz);
  endfunction

  function automatic logic [PK_W_MAX-1:0] pack_phy_cmd(input logic [PK_DATA_MAX-1:0] data,
                                                       input logic [PK_LEN_MAX-1:0]  len,
                                                       input logic [2:0]             cmd,
                                                       input int                     lw);
    logic [PK_W_MAX-1:0] pkt;
    pkt = {{(PK_LEN_MAX+3){1'b0}}, data} << (lw + 3);
    pkt = pkt | ({{(PK_DATA_MAX+3){1'b0}}, len} << 3) | PK_W_MAX'(cmd);
    return pkt;
  endfunction

endpackage

// File: rtl/jtag_scan_sched_rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins; pointer moves past the winner on advance.
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int PW  = $clog2(NREQ)
) (
  input  logic            PHY_CLK,
  input  logic            RESETn,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_advance,
  output logic [NREQ-1:0] o_gnt,
  output logic [PW-1:0]   o_idx,
  output logic [PW-1:0]   o_ptr
);

  logic [PW-1:0] r_ptr;
  logic [PW:0]   w_sum;
  logic          w_found;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_sum = {1'b0, r_ptr} + (PW+1)'(i);
      if (w_sum >= (PW+1)'(NREQ)) w_sum = w_sum - (PW+1)'(NREQ);
      if (!w_found && i_req[w_sum[PW-1:0]]) begin
        o_gnt[w_sum[PW-1:0]] = 1'b1;
        o_idx                = w_sum[PW-1:0];
        w_found              = 1'b1;
      end
    end
  end

  always_ff @(posedge PHY_CLK) begin
    if (!RESETn)        r_ptr <= '0;
    else if (i_advance) r_ptr <= (o_idx == PW'(NREQ-1)) ? '0 : o_idx + PW'(1);
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/jtag_scan_sched.sv
// Multi-requester scan scheduler: arbitrates requesters onto the JTAG PHY FIFOs,
// splits requests into IR/DR packets, skips redundant IR scans and routes read-back.
module jtag_scan_sched import jtag_pkg::*; #(
  parameter int  NREQ     = 4,
  parameter int  MAX_CLEN = 4096,
  parameter int  BUF_SZ   = 64,
  parameter int  IR_W     = 8,
  localparam int LW       = len_w(MAX_CLEN),
  localparam int BW       = buf_w(BUF_SZ)
) (
  input  logic                     PHY_CLK,
  input  logic                     RESETn,
  input  logic [NREQ-1:0]          REQ,
  output logic [NREQ-1:0]          GNT,
  input  logic [NREQ*IR_W-1:0]     HDR_IR,
  input  logic [NREQ*LW-1:0]       HDR_LEN,
  input  logic [NREQ-1:0]          HDR_RD,
  input  logic [NREQ*BUF_SZ-1:0]   WD_DATA,
  input  logic [NREQ-1:0]          WD_VALID,
  output logic [NREQ-1:0]          WD_READY,
  output logic [BUF_SZ-1:0]        RD_DATA,
  output logic [BW-1:0]            RD_LEN,
  output logic [NREQ-1:0]          RD_VALID,
  output logic [NREQ-1:0]          DONE,
  output logic [BUF_SZ+3+LW-1:0]   PHY_WRDATA,
  output logic                     PHY_WREN,
  input  logic                     PHY_WRFULL,
  input  logic [BUF_SZ+BW-1:0]     PHY_RDDATA,
  output logic                     PHY_RDEN,
  input  logic                     PHY_RDEMPTY
);

  localparam int PW    = $clog2(NREQ);
  localparam int CW    = LW - BW + 1;
  localparam int PKT_W = BUF_SZ + 3 + LW;

  state_t            r_state;
  logic [PW-1:0]     r_own;
  logic [NREQ-1:0]   r_gnt, r_done;
  logic [IR_W-1:0]   r_ir, r_cache_ir;
  logic              r_cache_vld;
  logic [LW-1:0]     r_len;
  logic              r_rd;
  logic [CW-1:0]     r_nchk, r_chunk, r_rsp;
  logic              r_rd_vld;

  logic [NREQ-1:0]   w_arb_gnt;
  logic [PW-1:0]     w_arb_idx, w_unused_rr_ptr;
  logic              w_arb_adv;
  logic [IR_W-1:0]   w_hdr_ir;
  logic [LW-1:0]     w_hdr_len, w_lenf, w_lenf_o;
  logic [LW:0]       w_len_rnd;
  logic [CW-1:0]     w_hdr_nchk;
  logic [BUF_SZ-1:0] w_data, w_wd_data;
  logic [2:0]        w_cmd;
  logic              w_push, w_wd_rdy, w_rden;
  logic [PK_W_MAX-1:0] w_pkt_full;
  logic              w_unused_pkt;

  assign w_arb_adv = (r_state == S_IDLE) && (|REQ);

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .PHY_CLK   (PHY_CLK),
    .RESETn    (RESETn),
    .i_req     (REQ),
    .i_advance (w_arb_adv),
    .o_gnt     (w_arb_gnt),
    .o_idx     (w_arb_idx),
    .o_ptr     (w_unused_rr_ptr)
  );

  assign w_hdr_ir   = HDR_IR[w_arb_idx*IR_W +: IR_W];
  assign w_hdr_len  = HDR_LEN[w_arb_idx*LW +: LW];
  assign w_len_rnd  = {1'b0, w_hdr_len} + (LW+1)'(BUF_SZ-1);
  assign w_hdr_nchk = w_len_rnd[LW:BW];
  assign w_wd_data  = WD_DATA[r_own*BUF_SZ +: BUF_SZ];
  assign w_lenf     = r_rd ? r_len - LW'(1) : r_len;

  // Push handshake is combinational so a full FIFO is never written.
  always_comb begin
    w_push   = 1'b0;
    w_wd_rdy = 1'b0;
    w_data   = '0;
    w_lenf_o = '0;
    w_cmd    = CMD_WR_DR;
    case (r_state)
      S_GRANT: w_push = (r_len == '0) && !PHY_WRFULL;
      S_IR: begin
        w_push   = !PHY_WRFULL;
        w_data   = BUF_SZ'(r_ir);
        w_lenf_o = LW'(IR_W);
        w_cmd    = CMD_WR_IR;
      end
      S_DR: begin
        w_lenf_o = w_lenf;
        w_cmd    = r_rd ? CMD_RD_DR : CMD_WR_DR;
        // An abandoned requester gets zero-filled chunks so the scan still completes.
        if (REQ[r_own]) begin
          w_data   = w_wd_data;
          w_push   = WD_VALID[r_own] && !PHY_WRFULL;
          w_wd_rdy = w_push;
        end else begin
          w_push   = !PHY_WRFULL;
        end
      end
      default: ;
    endcase
  end

  assign w_rden = ((r_state == S_DR) || (r_state == S_DRAIN)) && !PHY_RDEMPTY && (r_rsp != '0);

  assign w_pkt_full   = pack_phy_cmd(PK_DATA_MAX'(w_data), PK_LEN_MAX'(w_lenf_o), w_cmd, LW);
  assign w_unused_pkt = ^w_pkt_full[PK_W_MAX-1:PKT_W];

  assign PHY_WRDATA = w_pkt_full[PKT_W-1:0];
  assign PHY_WREN   = w_push;
  assign PHY_RDEN   = w_rden;
  assign WD_READY   = NREQ'(w_wd_rdy) << r_own;
  assign GNT        = r_gnt;
  assign DONE       = r_done;
  assign RD_VALID   = r_rd_vld ? r_gnt : '0;
  assign RD_DATA    = r_rd_vld ? PHY_RDDATA[BW +: BUF_SZ] : '0;
  assign RD_LEN     = r_rd_vld ? PHY_RDDATA[BW-1:0] : '0;

  // Datapath header/chunk registers are only meaningful after a grant and need no reset.
  always_ff @(posedge PHY_CLK) begin
    if (!RESETn) begin
      r_state     <= S_IDLE;
      r_own       <= '0;
      r_gnt       <= '0;
      r_done      <= '0;
      r_cache_vld <= 1'b0;
      r_rsp       <= '0;
      r_rd_vld    <= 1'b0;
    end else begin
      r_rd_vld <= w_rden;
      r_done   <= '0;
      if (w_rden) r_rsp <= r_rsp - CW'(1);
      case (r_state)
        S_IDLE: if (|REQ) begin
          r_own   <= w_arb_idx;
          r_gnt   <= w_arb_gnt;
          r_ir    <= w_hdr_ir;
          r_len   <= w_hdr_len;
          r_rd    <= HDR_RD[w_arb_idx];
          r_nchk  <= w_hdr_nchk;
          r_rsp   <= HDR_RD[w_arb_idx] ? w_hdr_nchk : '0;
          r_chunk <= '0;
          r_state <= S_GRANT;
        end
        S_GRANT: begin
          if (r_len == '0) begin
            if (w_push) begin
              r_cache_vld <= 1'b0;
              r_done      <= r_gnt;
              r_state     <= S_FIN;
            end
          end else if (!r_cache_vld || (r_cache_ir != r_ir)) begin
            r_state <= S_IR;
          end else begin
            r_state <= S_DR;
          end
        end
        S_IR: if (w_push) begin
          r_cache_vld <= 1'b1;
          r_cache_ir  <= r_ir;
          r_state     <= S_DR;
        end
        S_DR: if (w_push) begin
          if (r_chunk == r_nchk - CW'(1)) r_state <= S_DRAIN;
          else                            r_chunk <= r_chunk + CW'(1);
        end
        S_DRAIN: if (r_rsp == '0) begin
          r_done  <= r_gnt;
          r_state <= S_FIN;
        end
        S_FIN: begin
          r_gnt   <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
